ets_sweep_scheduler: RTL
========================

# ets_sweep_scheduler

Sequencer that drives the offset sampler through a full equivalent-time sweep. For each DUT signal select in a configured range, it steps the ETS-clock PLL phase through every position. At each phase it runs one sampler measurement and pushes the tagged one-count into an output FIFO, which the SPI host drains. The block sits between the SPI register file, the offset sampler and the dynamic-phase-shift PLL.

## Interface
- PHASE_STEPS, 64: PLL phase steps per full ETS-clock rotation; ≤256.
- SETTLE_CYCLES, 8: idle cycles after a phase step completes and before a run.
- FIFO_DEPTH, 16: result FIFO entries; power of two.

- clk  in  1  system clock; also the sampler's `clk`.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sweep; ignored unless idle.
- abort  in  1  one-cycle pulse; terminates the sweep.
- cfg_first_signal  in  8  first signal select.
- cfg_last_signal  in  8  last signal select, inclusive.
- cfg_total_cycles  in  32  iterations per measurement.
- smp_request_run  out  1  to sampler `request_run`.
- smp_running  in  1  from sampler `running`.
- smp_result_ready  in  1  from sampler `result_ready`.
- smp_result  in  32  from sampler `result`.
- smp_signal_select  out  32  to sampler; zero-extended current signal.
- smp_total_cycles  out  32  to sampler; latched cfg_total_cycles.
- phase_step  out  1  one-cycle pulse; advance PLL phase by one step.
- phase_done  in  1  PLL acknowledge pulse for a step.
- fifo_rd_en  in  1  pop request.
- fifo_rd_data  out  48  {signal[7:0], phase[7:0], count[31:0]}; valid when !fifo_empty.
- fifo_empty  out  1  FIFO has no entries.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sweep end, abort or error.
- error  out  1  sticky error flag; cleared by start.

## Operation
- Reset (asynchronous) sets state IDLE, clears the FIFO, and zeroes all outputs. fifo_empty resets to 1.
- Configuration is latched on an accepted start. Start also flushes the FIFO and clears error. signal = first, phase = 0.
- If cfg_last_signal < cfg_first_signal at start: set error, pulse done, return to IDLE. No points are measured.
- FSM:
  - IDLE: on start → SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles → RUN.
  - RUN: hold smp_request_run high until smp_running is seen high while smp_result_ready is low → WAIT.
  - WAIT: on smp_result_ready, capture smp_result → PUSH.
  - PUSH: write {signal, phase, count} when the FIFO is not full. Stall in PUSH while full; no data is lost. After the write → STEP.
  - STEP: pulse phase_step → STEP_WAIT.
  - STEP_WAIT: on phase_done, advance phase.
    - If phase wraps PHASE_STEPS-1→0 and signal == last → DONE.
    - If phase wraps and signal < last: signal+1 → SETTLE.
    - Otherwise → SETTLE.
  - DRAIN: wait for smp_running low → DONE.
  - DONE: pulse done → IDLE.
- The final point is always followed by a wrap step, so the PLL ends at phase 0.
- Abort in SETTLE, STEP or STEP_WAIT → DONE.
- Abort in RUN, WAIT or PUSH → DRAIN. Any in-flight result is discarded, and smp_request_run drops next cycle.
- Abort in IDLE is ignored. When start and abort arrive together, abort wins.
- FIFO behaviour:
  - Pop on fifo_rd_en when not empty; pop when empty is ignored.
  - Simultaneous push and pop keeps fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - FIFO contents survive done and abort; only start or reset flushes them.

## Timing
- start at cycle N → busy at N+1 → smp_request_run high at N+1+SETTLE_CYCLES.
- smp_result_ready at cycle M → FIFO write at M+2 (FIFO not full) → phase_step at M+3.
- phase_done at cycle P → next smp_request_run at P+1+SETTLE_CYCLES.
- fifo_rd_data is first-word-fall-through. It shows the head entry combinationally from registered storage; pop takes effect on the next edge.
- done is exactly one cycle wide. busy falls in the cycle after done.

## Configuration
- ETS_PHASE_TIMEOUT_EN defined:
  - STEP_WAIT runs a 10-bit timer.
  - If 1024 cycles pass without phase_done: set error → DONE.
  - The phase is left wherever the PLL stopped.
- ETS_PHASE_TIMEOUT_EN undefined: STEP_WAIT waits indefinitely; error is set only by an invalid range.

## Test plan
- PHASE_STEPS=4, first=last=2, sampler model returns 10,11,12,13:
  - four entries {2,0,10} … {2,3,13};
  - four phase_step pulses;
  - one done pulse.
- first=1, last=2, PHASE_STEPS=4: eight entries; signal tag goes 1→2 after phase 3; the last entry is {2,3,x}.
- Hold fifo_rd_en low with FIFO_DEPTH=4, eight points: the FSM stalls in PUSH at fifo_level=4; popping resumes it; all eight entries arrive in order.
- Abort while in WAIT with smp_running high:
  - smp_request_run drops;
  - done follows smp_running falling;
  - the discarded result is not pushed;
  - earlier entries stay intact.
- first=5, last=3: error=1, done pulse, zero entries, phase_step never pulsed.
- ETS_PHASE_TIMEOUT_EN defined, phase_done withheld: error=1 and done exactly 1024 cycles after phase_step.

Source files
------------

// File: rtl/ets_sweep_scheduler.sv
// Equivalent-time sweep sequencer: walks signal selects x PLL phases, runs one sampler
// measurement per point and queues tagged results. Define ETS_PHASE_TIMEOUT_EN for a phase_done timeout.
module ets_sweep_scheduler #(
    parameter int PHASE_STEPS   = 64,
    parameter int SETTLE_CYCLES = 8,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [7:0]                  cfg_first_signal,
    input  logic [7:0]                  cfg_last_signal,
    input  logic [31:0]                 cfg_total_cycles,
    output logic                        smp_request_run,
    input  logic                        smp_running,
    input  logic                        smp_result_ready,
    input  logic [31:0]                 smp_result,
    output logic [31:0]                 smp_signal_select,
    output logic [31:0]                 smp_total_cycles,
    output logic                        phase_step,
    input  logic                        phase_done,
    input  logic                        fifo_rd_en,
    output logic [47:0]                 fifo_rd_data,
    output logic                        fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);
    // state      | meaning
    // IDLE       | waiting for start
    // SETTLE     | settle delay after a phase move
    // RUN        | requesting a sampler run
    // WAIT       | sampler running, waiting for its result
    // PUSH       | writing the tagged result (stalls while FIFO full)
    // STEP       | issue one phase_step
    // STEP_WAIT  | waiting for the PLL acknowledge
    // DRAIN      | aborted mid-measurement, waiting for sampler to stop
    // DONE       | one-cycle done pulse
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SETTLE    = 4'd1;
    localparam logic [3:0] S_RUN       = 4'd2;
    localparam logic [3:0] S_WAIT      = 4'd3;
    localparam logic [3:0] S_PUSH      = 4'd4;
    localparam logic [3:0] S_STEP      = 4'd5;
    localparam logic [3:0] S_STEP_WAIT = 4'd6;
    localparam logic [3:0] S_DRAIN     = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [7:0]    LAST_PHASE  = 8'(PHASE_STEPS - 1);
    localparam logic [AW:0]   FULL_LEVEL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   LVL_ONE     = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);

    logic [3:0]    state;
    logic [SW-1:0] settle_cnt;
    logic [7:0]    cur_signal;
    logic [7:0]    last_signal;
    logic [7:0]    phase;
    logic [31:0]   total_cycles;
    logic [31:0]   count;
    logic          error_q;
    logic          phase_step_q;
    logic [47:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          accept_start;
    logic          fifo_full;
    logic          push;
    logic          pop;
`ifdef ETS_PHASE_TIMEOUT_EN
    logic [9:0]    step_timer;
`endif

    assign accept_start = (state == S_IDLE) && start && !abort;
    assign fifo_full    = (level == FULL_LEVEL);
    assign push         = (state == S_PUSH) && !abort && !fifo_full;
    assign pop          = fifo_rd_en && (level != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            settle_cnt   <= '0;
            cur_signal   <= '0;
            last_signal  <= '0;
            phase        <= '0;
            total_cycles <= '0;
            count        <= '0;
            error_q      <= 1'b0;
            phase_step_q <= 1'b0;
`ifdef ETS_PHASE_TIMEOUT_EN
            step_timer   <= '0;
`endif
        end else begin
            // Registered so the PLL sees a clean pulse; suppressed if STEP is aborted.
            phase_step_q <= (state == S_STEP) && !abort;
            case (state)
                S_IDLE: begin
                    if (accept_start) begin
                        cur_signal   <= cfg_first_signal;
                        last_signal  <= cfg_last_signal;
                        phase        <= '0;
                        total_cycles <= cfg_total_cycles;
                        error_q      <= (cfg_last_signal < cfg_first_signal);
                        if (cfg_last_signal < cfg_first_signal) begin
                            state <= S_DONE;
                        end else begin
                            state      <= S_SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
                end
                S_SETTLE: begin
                    if (abort)                  state <= S_DONE;
                    else if (settle_cnt == '0)  state <= S_RUN;
                    else                        settle_cnt <= settle_cnt - SETTLE_ONE;
                end
                S_RUN: begin
                    if (abort)                                       state <= S_DRAIN;
                    else if (smp_running && !smp_result_ready)       state <= S_WAIT;
                end
                S_WAIT: begin
                    if (abort) begin
                        state <= S_DRAIN;
                    end else if (smp_result_ready) begin
                        count <= smp_result;
                        state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (abort)           state <= S_DRAIN;
                    else if (!fifo_full) state <= S_STEP;
                end
                S_STEP: begin
                    if (abort) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_STEP_WAIT;
`ifdef ETS_PHASE_TIMEOUT_EN
                        step_timer <= 10'd1023;
`endif
                    end
                end
                S_STEP_WAIT: begin
                    if (abort) begin
                        state <= S_DONE;
                    end else if (phase_done) begin
                        if (phase == LAST_PHASE) begin
                            phase <= '0;
                            if (cur_signal == last_signal) begin
                                state <= S_DONE;
                            end else begin
                                cur_signal <= cur_signal + 8'd1;
                                state      <= S_SETTLE;
                                settle_cnt <= SETTLE_LOAD;
                            end
                        end else begin
                            phase      <= phase + 8'd1;
                            state      <= S_SETTLE;
                            settle_cnt <= SETTLE_LOAD;
                        end
                    end
`ifdef ETS_PHASE_TIMEOUT_EN
                    else if (step_timer == '0) begin
                        error_q <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        step_timer <= step_timer - 10'd1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (!smp_running) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (accept_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {cur_signal, phase, count};
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      level <= level + LVL_ONE;
            else if (pop && !push) level <= level - LVL_ONE;
        end
    end

    assign smp_request_run   = (state == S_RUN);
    assign smp_signal_select = {24'd0, cur_signal};
    assign smp_total_cycles  = total_cycles;
    assign phase_step        = phase_step_q;
    assign fifo_rd_data      = mem[rd_ptr];
    assign fifo_empty        = (level == '0);
    assign fifo_level        = level;
    assign busy              = (state != S_IDLE);
    assign done              = (state == S_DONE);
    assign error             = error_q;

endmodule
